// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with per-register pending-write
// scoreboard and a sequenced soft-clear engine.
// Optional build macro: RF_BYPASS_EN enables same-cycle write-to-read forwarding.
//
// Handshake note: there is no valid/ready flow control. wr_en, issue_en,
// init_R0 and clear_req are single-cycle strobes sampled at the rising edge
// while the FSM is IDLE; they are silently dropped while clear_busy is high.
module register_file_sb #(
  parameter int REG_WIDTH  = 8,
  parameter int REG_COUNT  = 16,
  parameter int READ_PORTS = 3,
  parameter int PTR_W      = $clog2(REG_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset_RF_n,
  input  logic                          clear_req,
  output logic                          clear_busy,
  input  logic                          init_R0,
  input  logic [REG_WIDTH-1:0]          init_R0_data,
  input  logic                          wr_en,
  input  logic [PTR_W-1:0]              wr_dst,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic                          issue_en,
  input  logic [PTR_W-1:0]              issue_dst,
  input  logic [READ_PORTS*PTR_W-1:0]   rd_ptr,
  output logic [READ_PORTS*REG_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]         rd_busy,
  output logic                          dbg_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]   regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0]   regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]   busy_q, busy_d;

  assign clear_busy = (state_q == CLEAR);
  assign dbg_state  = state_q;

  // Next-state for FSM, clear counter, register contents and busy bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          regs_d[wr_dst] = wr_data;
          busy_d[wr_dst] = 1'b0;
        end
        // R0 init overrides a same-cycle write-back to R0 for data only.
        if (init_R0) regs_d[0] = init_R0_data;
        // A newly issued producer outranks a completing one on the same register.
        if (issue_en) busy_d[issue_dst] = 1'b1;
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == PTR_W'(REG_COUNT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_RF_n) begin
    if (!reset_RF_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Combinational read ports, each independently addressed.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [PTR_W-1:0]     ptr;
    logic [REG_WIDTH-1:0] data;
    logic                 busy;

    assign ptr = rd_ptr[p*PTR_W +: PTR_W];

    // Read mux, optionally forwarding the in-flight write-back.
    always_comb begin
      data = regs_q[ptr];
      busy = busy_q[ptr];
`ifdef RF_BYPASS_EN
      if ((state_q == IDLE) && wr_en && (wr_dst == ptr)) begin
        data = wr_data;
        busy = issue_en && (issue_dst == ptr);
        if (init_R0 && (ptr == '0)) data = init_R0_data;
      end
`endif
    end

    assign rd_data[p*REG_WIDTH +: REG_WIDTH] = data;
    assign rd_busy[p] = busy;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb (8-bit, 16 regs, 3 ports).
module tb_register_file_sb;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int NP = 3;
  localparam int PW = 4;

  logic            clk;
  logic            reset_RF_n;
  logic            clear_req;
  logic            clear_busy;
  logic            init_R0;
  logic [W-1:0]    init_R0_data;
  logic            wr_en;
  logic [PW-1:0]   wr_dst;
  logic [W-1:0]    wr_data;
  logic            issue_en;
  logic [PW-1:0]   issue_dst;
  logic [NP*PW-1:0] rd_ptr;
  logic [NP*W-1:0] rd_data;
  logic [NP-1:0]   rd_busy;
  logic            dbg_state;

  int checks = 0;
  int errors = 0;

  register_file_sb #(.REG_WIDTH(W), .REG_COUNT(N), .READ_PORTS(NP)) dut (
    .clk          (clk),
    .reset_RF_n   (reset_RF_n),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .init_R0      (init_R0),
    .init_R0_data (init_R0_data),
    .wr_en        (wr_en),
    .wr_dst       (wr_dst),
    .wr_data      (wr_data),
    .issue_en     (issue_en),
    .issue_dst    (issue_dst),
    .rd_ptr       (rd_ptr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 0; init_R0 = 0; init_R0_data = '0;
    wr_en = 0; wr_dst = '0; wr_data = '0;
    issue_en = 0; issue_dst = '0;
  endtask

  task automatic set_ptr(input int p, input int r);
    rd_ptr[p*PW +: PW] = PW'(r);
    #1;
  endtask

  function automatic logic [W-1:0] data_of(input int p);
    return rd_data[p*W +: W];
  endfunction

  task automatic write(input int r, input logic [W-1:0] d);
    wr_en = 1; wr_dst = PW'(r); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rd_ptr = '0;
    reset_RF_n = 0;
    #12;
    // Reset state
    set_ptr(0, 0); set_ptr(1, 5); set_ptr(2, 15);
    check("rst_data", rd_data, '0);
    check("rst_busy", rd_busy, '0);
    check("rst_clear_busy", clear_busy, 0);
    tick();
    reset_RF_n = 1;
    tick();

    // Reset then write
    write(5, 8'hA5);
    set_ptr(0, 5);
    check("wr5_data", data_of(0), 8'hA5);
    check("wr5_busy", rd_busy[0], 0);
    for (int i = 0; i < N; i++) begin
      if (i != 5) begin
        set_ptr(1, i);
        check("other_zero", data_of(1), 0);
      end
    end

    // Scoreboard: issue then write-back
    issue_en = 1; issue_dst = 3;
    tick();
    issue_en = 0;
    set_ptr(1, 3);
    check("issue3_busy", rd_busy[1], 1);
    write(3, 8'h11);
    check("wb3_busy", rd_busy[1], 0);
    check("wb3_data", data_of(1), 8'h11);

    // Same-cycle issue and write to r7: new producer wins busy
    issue_en = 1; issue_dst = 7;
    write(7, 8'h5A);
    issue_en = 0;
    set_ptr(2, 7);
    check("same7_busy", rd_busy[2], 1);
    check("same7_data", data_of(2), 8'h5A);

    // Different registers in the same cycle
    issue_en = 1; issue_dst = 8;
    write(6, 8'h66);
    issue_en = 0;
    set_ptr(0, 8); set_ptr(1, 6);
    check("diff_busy8", rd_busy[0], 1);
    check("diff_data6", data_of(1), 8'h66);
    check("diff_busy6", rd_busy[1], 0);

    // Re-issue on busy r8; one write-back clears it
    issue_en = 1; issue_dst = 8;
    tick();
    issue_en = 0;
    check("reissue_busy", rd_busy[0], 1);
    write(8, 8'h88);
    check("reissue_clr", rd_busy[0], 0);

    // R0 priority: init beats write data, write still clears busy
    issue_en = 1; issue_dst = 0;
    tick();
    issue_en = 0;
    init_R0 = 1; init_R0_data = 8'h3C;
    write(0, 8'hFF);
    init_R0 = 0;
    set_ptr(0, 0);
    check("r0_data", data_of(0), 8'h3C);
    check("r0_busy", rd_busy[0], 0);

    // Bypass: same-cycle write and read of r4
    set_ptr(2, 4);
    wr_en = 1; wr_dst = 4; wr_data = 8'h77;
    #1;
`ifdef RF_BYPASS_EN
    check("byp_same", data_of(2), 8'h77);
`else
    check("byp_same", data_of(2), 8'h00);
`endif
    tick();
    wr_en = 0;
    check("byp_next", data_of(2), 8'h77);

    // Soft clear: fill, mark r2 busy, then clear
    for (int i = 0; i < N; i++) write(i, 8'(8'h10 + i));
    issue_en = 1; issue_dst = 2;
    tick();
    issue_en = 0;
    set_ptr(0, 2); set_ptr(1, 12);
    check("fill_r12", data_of(1), 8'h1C);
    check("fill_busy2", rd_busy[0], 1);
    clear_req = 1;
    tick();
    clear_req = 0;
    set_ptr(0, 0);
    n = 0;
    while (clear_busy && n < 40) begin
      n++;
      if (n == 3) begin
        // r0 already cleared; this write and issue must be dropped
        wr_en = 1; wr_dst = 0; wr_data = 8'hAA;
        issue_en = 1; issue_dst = 1;
      end else begin
        wr_en = 0; issue_en = 0;
      end
      if (n == 5) begin
        check("mid_r0", data_of(0), 0);
        check("mid_r12", data_of(1), 8'h1C);
      end
      tick();
    end
    wr_en = 0; issue_en = 0;
    check("clear_len", n, N);
    for (int i = 0; i < N; i++) begin
      set_ptr(2, i);
      check("clr_data", data_of(2), 0);
      check("clr_busy", rd_busy[2], 0);
    end

    // Reset mid-clear
    write(15, 8'h99);
    clear_req = 1;
    tick();
    clear_req = 0;
    n = 1;
    while (n < 6) begin
      tick();
      n++;
    end
    check("pre_rst_busy", clear_busy, 1);
    set_ptr(1, 15);
    check("pre_rst_r15", data_of(1), 8'h99);
    reset_RF_n = 0;
    #1;
    check("rst_mid_busy", clear_busy, 0);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_r15", data_of(1), 0);
    tick();
    reset_RF_n = 1;
    tick();
    write(9, 8'h42);
    set_ptr(0, 9);
    check("post_rst_r9", data_of(0), 8'h42);
    check("post_rst_idle", clear_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
